// File: rtl/snake_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : snake_mem_pkg
//  Description : Shared constants and types for the snake board memory
//                arbiter and its round-robin helper.
//  Revision    : 1.0  initial release
// ============================================================================
package snake_mem_pkg;

    // Board geometry
    localparam int BOARD_DEPTH = 760;
    localparam int BOARD_AW    = 10;
    localparam int BOARD_DW    = 8;

    // Requester indices on the shared port
    localparam int REQ_GAME = 0;
    localparam int REQ_LCD  = 1;

    // Arbiter FSM state encoding
    typedef logic [0:0] arb_state_t;
    localparam arb_state_t ST_IDLE  = 1'b0;
    localparam arb_state_t ST_CLEAR = 1'b1;

endpackage : snake_mem_pkg
`default_nettype wire

// File: rtl/snake_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : snake_rr_arb2
//  Description : Two-way round-robin arbiter. A lone request is granted
//                directly; on contention the pointer's requester wins and
//                the pointer flips when advance_i accepts the grant.
//  Revision    : 1.0  initial release
// ============================================================================
module snake_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o,
    output logic       ptr_o
);

    logic ptr_q;
    logic ptr_d;

    // One-hot grant from the request vector and the priority pointer
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
    end

    // Pointer only moves when a contended grant is actually taken
    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && (&req_i)) begin
            ptr_d = ~ptr_q;
        end
    end

    // Pointer register, starts at requester 0
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule : snake_rr_arb2
`default_nettype wire

// File: rtl/snake_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : snake_mem_arbiter
//  Description : Shares memory port 2 of the snake board between the game
//                logic and the LCD renderer, with a board-clear engine.
//                Optional macro SNAKE_MEM_ARB_STATS_EN adds saturating
//                grant/conflict counters.
//  Revision    : 1.0  initial release
// ============================================================================
module snake_mem_arbiter
    import snake_mem_pkg::*;
#(
    parameter int DEPTH = BOARD_DEPTH,
    parameter int AW    = BOARD_AW,
    parameter int DW    = BOARD_DW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      req_i,
    input  logic [1:0]      we_i,
    input  logic [2*AW-1:0] addr_i,
    input  logic [2*DW-1:0] wdata_i,
    output logic [1:0]      gnt_o,
    output logic [1:0]      rvalid_o,
    output logic [DW-1:0]   rdata_o,
    input  logic            clear_start,
    input  logic [DW-1:0]   clear_value,
    output logic            clear_busy,
    output logic            clear_done,
    output logic            addr_err,
    output logic [AW-1:0]   mem_address,
    output logic            mem_chipselect,
    output logic            mem_write,
    output logic [DW-1:0]   mem_writedata,
    output logic            mem_clken,
`ifdef SNAKE_MEM_ARB_STATS_EN
    output logic [15:0]     grant_cnt0,
    output logic [15:0]     grant_cnt1,
    output logic [15:0]     conflict_cnt,
`endif
    input  logic [DW-1:0]   mem_readdata
);

    localparam logic [AW-1:0] C_CLR_LAST = AW'(DEPTH - 1);
    localparam logic [AW:0]   C_DEPTH    = (AW + 1)'(DEPTH);

    arb_state_t    state_q, state_d;
    logic [AW-1:0] clr_addr_q, clr_addr_d;
    logic [DW-1:0] clr_val_q, clr_val_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          mem_cs_q, mem_cs_d;
    logic          mem_we_q, mem_we_d;
    logic [DW-1:0] mem_wd_q, mem_wd_d;
    logic [1:0]    rd1_q, rd1_d;
    logic          oor1_q, oor1_d;
    logic [1:0]    rd2_q;
    logic          oor2_q;
    logic          aerr_q, aerr_d;

    logic          w_arb_en;
    logic [1:0]    w_arb_req;
    logic [1:0]    w_gnt;
    logic          w_ptr;
    logic          w_sel;
    logic [AW-1:0] w_addr;
    logic          w_we;
    logic [DW-1:0] w_wd;
    logic          w_in_range;
    logic          w_clr_last;

    // Requests only compete in IDLE when no clear is being launched
    assign w_arb_en  = (state_q == ST_IDLE) && !clear_start;
    assign w_arb_req = w_arb_en ? req_i : 2'b00;

    snake_rr_arb2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .req_i     (w_arb_req),
        .advance_i (w_arb_en),
        .gnt_o     (w_gnt),
        .ptr_o     (w_ptr)
    );

    // Winning requester index: LCD if it asks alone or holds priority
    assign w_sel      = w_arb_req[REQ_LCD] & (~w_arb_req[REQ_GAME] | w_ptr);
    assign w_addr     = w_sel ? addr_i[REQ_LCD*AW +: AW]  : addr_i[REQ_GAME*AW +: AW];
    assign w_wd       = w_sel ? wdata_i[REQ_LCD*DW +: DW] : wdata_i[REQ_GAME*DW +: DW];
    assign w_we       = w_sel ? we_i[REQ_LCD] : we_i[REQ_GAME];
    assign w_in_range = {1'b0, w_addr} < C_DEPTH;
    assign w_clr_last = (state_q == ST_CLEAR) && (clr_addr_q == C_CLR_LAST);

    // FSM, command slot and read-pipeline stage 1 next-state
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        clr_val_d  = clr_val_q;
        mem_addr_d = mem_addr_q;
        mem_wd_d   = mem_wd_q;
        mem_cs_d   = 1'b0;
        mem_we_d   = 1'b0;
        rd1_d      = 2'b00;
        oor1_d     = 1'b0;
        aerr_d     = aerr_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_start) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                    clr_val_d  = clear_value;
                end else if (|w_gnt) begin
                    // Out-of-range slots are granted but kept off the bus
                    mem_addr_d = w_addr;
                    mem_wd_d   = w_wd;
                    mem_cs_d   = w_in_range;
                    mem_we_d   = w_in_range & w_we;
                    rd1_d      = w_we ? 2'b00 : w_gnt;
                    oor1_d     = ~w_in_range;
                    if (!w_in_range) begin
                        aerr_d = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                mem_addr_d = clr_addr_q;
                mem_wd_d   = clr_val_q;
                mem_cs_d   = 1'b1;
                mem_we_d   = 1'b1;
                if (w_clr_last) begin
                    state_d = ST_IDLE;
                end else begin
                    clr_addr_d = clr_addr_q + AW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, command and read-pipeline registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            clr_addr_q <= '0;
            clr_val_q  <= '0;
            mem_addr_q <= '0;
            mem_cs_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_wd_q   <= '0;
            rd1_q      <= 2'b00;
            oor1_q     <= 1'b0;
            rd2_q      <= 2'b00;
            oor2_q     <= 1'b0;
            aerr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            clr_val_q  <= clr_val_d;
            mem_addr_q <= mem_addr_d;
            mem_cs_q   <= mem_cs_d;
            mem_we_q   <= mem_we_d;
            mem_wd_q   <= mem_wd_d;
            rd1_q      <= rd1_d;
            oor1_q     <= oor1_d;
            rd2_q      <= rd1_q;
            oor2_q     <= oor1_q;
            aerr_q     <= aerr_d;
        end
    end

    assign gnt_o          = w_gnt;
    assign rvalid_o       = rd2_q;
    assign rdata_o        = ((|rd2_q) && !oor2_q) ? mem_readdata : '0;
    assign clear_busy     = (state_q == ST_CLEAR) && !w_clr_last;
    assign clear_done     = w_clr_last;
    assign addr_err       = aerr_q;
    assign mem_address    = mem_addr_q;
    assign mem_chipselect = mem_cs_q;
    assign mem_write      = mem_we_q;
    assign mem_writedata  = mem_wd_q;
    assign mem_clken      = 1'b1;

`ifdef SNAKE_MEM_ARB_STATS_EN
    logic [15:0] gcnt0_q, gcnt1_q, ccnt_q;

    // Saturating grant and contention counters
    always_ff @(posedge clk) begin
        if (reset) begin
            gcnt0_q <= '0;
            gcnt1_q <= '0;
            ccnt_q  <= '0;
        end else begin
            if (w_gnt[REQ_GAME] && (gcnt0_q != 16'hFFFF)) gcnt0_q <= gcnt0_q + 16'd1;
            if (w_gnt[REQ_LCD]  && (gcnt1_q != 16'hFFFF)) gcnt1_q <= gcnt1_q + 16'd1;
            if ((&req_i)        && (ccnt_q  != 16'hFFFF)) ccnt_q  <= ccnt_q + 16'd1;
        end
    end

    assign grant_cnt0   = gcnt0_q;
    assign grant_cnt1   = gcnt1_q;
    assign conflict_cnt = ccnt_q;
`endif

endmodule : snake_mem_arbiter
`default_nettype wire

// File: tb/tb_snake_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_snake_mem_arbiter
//  Description : Scoreboard bench for snake_mem_arbiter with a behavioural
//                model of memory port 2 and a cycle reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_snake_mem_arbiter;
    import snake_mem_pkg::*;

    localparam int DEPTH = BOARD_DEPTH;
    localparam int AW    = BOARD_AW;
    localparam int DW    = BOARD_DW;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [1:0]      req_i = '0;
    logic [1:0]      we_i = '0;
    logic [2*AW-1:0] addr_i = '0;
    logic [2*DW-1:0] wdata_i = '0;
    logic            clear_start = 1'b0;
    logic [DW-1:0]   clear_value = '0;
    logic [1:0]      gnt_o, rvalid_o;
    logic [DW-1:0]   rdata_o;
    logic            clear_busy, clear_done, addr_err;
    logic [AW-1:0]   mem_address;
    logic            mem_chipselect, mem_write, mem_clken;
    logic [DW-1:0]   mem_writedata, mem_readdata;
`ifdef SNAKE_MEM_ARB_STATS_EN
    logic [15:0]     grant_cnt0, grant_cnt1, conflict_cnt;
`endif

    always #5 clk = ~clk;

    snake_mem_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .req_i          (req_i),
        .we_i           (we_i),
        .addr_i         (addr_i),
        .wdata_i        (wdata_i),
        .gnt_o          (gnt_o),
        .rvalid_o       (rvalid_o),
        .rdata_o        (rdata_o),
        .clear_start    (clear_start),
        .clear_value    (clear_value),
        .clear_busy     (clear_busy),
        .clear_done     (clear_done),
        .addr_err       (addr_err),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
`ifdef SNAKE_MEM_ARB_STATS_EN
        .grant_cnt0     (grant_cnt0),
        .grant_cnt1     (grant_cnt1),
        .conflict_cnt   (conflict_cnt),
`endif
        .mem_readdata   (mem_readdata)
    );

    // Memory port 2: registered address, unregistered read data
    logic [DW-1:0] mem [0:1023];
    logic [AW-1:0] mem_areg = '0;
    always @(posedge clk) begin
        if (mem_chipselect && mem_write) mem[mem_address] <= mem_writedata;
        if (mem_clken) mem_areg <= mem_address;
    end
    assign mem_readdata = mem[mem_areg];

    // Checking
    int n_vec = 0;
    int n_bad = 0;
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model state
    typedef struct {
        int         due;
        logic [1:0] who;
        logic [7:0] data;
    } rd_exp_t;
    rd_exp_t       sb[$];
    logic [DW-1:0] ref_mem [0:1023];
    bit            run_chk = 0;
    int            cyc = 0;
    int            n_done = 0;
    bit            m_clr = 0;
    int            m_cnt = 0;
    logic [DW-1:0] m_val = '0;
    bit            m_ptr = 0;
    bit            m_aerr = 0;
    bit            m_cs = 0, m_we = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wd = '0;
    logic [1:0]    e_gnt;
    bit            e_busy, e_done;
    int            r_idx;
    logic [AW-1:0] r_addr;
    rd_exp_t       e_rd;

    always @(negedge clk) begin
        if (run_chk) begin
            if (clear_done) n_done++;
            e_gnt = 2'b00; e_busy = 0; e_done = 0;
            if (m_clr) begin
                e_done = (m_cnt == DEPTH - 1);
                e_busy = !e_done;
            end else if (!clear_start) begin
                case (req_i)
                    2'b01: e_gnt = 2'b01;
                    2'b10: e_gnt = 2'b10;
                    2'b11: e_gnt = m_ptr ? 2'b10 : 2'b01;
                    default: e_gnt = 2'b00;
                endcase
            end
            check_val("gnt", 32'(gnt_o), 32'(e_gnt));
            check_val("busy", 32'(clear_busy), 32'(e_busy));
            check_val("done", 32'(clear_done), 32'(e_done));
            check_val("cs", 32'(mem_chipselect), 32'(m_cs));
            check_val("wr", 32'(mem_write), 32'(m_we));
            if (m_cs) check_val("maddr", 32'(mem_address), 32'(m_addr));
            if (m_we) check_val("mwdata", 32'(mem_writedata), 32'(m_wd));
            check_val("aerr", 32'(addr_err), 32'(m_aerr));
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e_rd = sb.pop_front();
                check_val("rvalid", 32'(rvalid_o), 32'(e_rd.who));
                check_val("rdata", 32'(rdata_o), 32'(e_rd.data));
            end else begin
                check_val("rvalid_idle", 32'(rvalid_o), 32'd0);
            end
            // advance the model across the coming rising edge
            if (reset) begin
                m_clr = 0; m_ptr = 0; m_aerr = 0; m_cs = 0; m_we = 0;
                m_addr = '0; m_wd = '0; sb.delete();
            end else begin
                m_cs = 0; m_we = 0;
                if (m_clr) begin
                    m_cs = 1; m_we = 1; m_addr = AW'(m_cnt); m_wd = m_val;
                    ref_mem[m_cnt] = m_val;
                    if (m_cnt == DEPTH - 1) m_clr = 0;
                    else m_cnt++;
                end else if (clear_start) begin
                    m_clr = 1; m_cnt = 0; m_val = clear_value;
                end else if (e_gnt != 2'b00) begin
                    r_idx  = e_gnt[1] ? 1 : 0;
                    r_addr = addr_i[r_idx*AW +: AW];
                    if (req_i == 2'b11) m_ptr = ~m_ptr;
                    m_addr = r_addr;
                    m_wd   = wdata_i[r_idx*DW +: DW];
                    if (int'(r_addr) < DEPTH) begin
                        m_cs = 1;
                        m_we = we_i[r_idx];
                        if (we_i[r_idx]) ref_mem[r_addr] = m_wd;
                        else sb.push_back('{cyc + 2, e_gnt, ref_mem[r_addr]});
                    end else begin
                        m_aerr = 1;
                        if (!we_i[r_idx]) sb.push_back('{cyc + 2, e_gnt, 8'h00});
                    end
                end
            end
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold a request until granted (bounded)
    task automatic do_req(input int r, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        bit got;
        n = 0; got = 0;
        req_i[r] = 1'b1;
        we_i[r]  = we;
        addr_i[r*AW +: AW]  = a;
        wdata_i[r*DW +: DW] = d;
        while (!got && n < 2000) begin
            #1;
            got = gnt_o[r];
            tick();
            n++;
        end
        req_i[r] = 1'b0;
        we_i[r]  = 1'b0;
        if (!got) check_val("req_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = 8'(i) ^ 8'h5A;
            ref_mem[i] = 8'(i) ^ 8'h5A;
        end
        mem[5]     = 8'h3C;
        ref_mem[5] = 8'h3C;

        // Reset state
        repeat (2) tick();
        check_val("rst_gnt", 32'(gnt_o), 32'd0);
        check_val("rst_rvalid", 32'(rvalid_o), 32'd0);
        check_val("rst_rdata", 32'(rdata_o), 32'd0);
        check_val("rst_busy", 32'(clear_busy), 32'd0);
        check_val("rst_done", 32'(clear_done), 32'd0);
        check_val("rst_aerr", 32'(addr_err), 32'd0);
        check_val("rst_maddr", 32'(mem_address), 32'd0);
        check_val("rst_cs", 32'(mem_chipselect), 32'd0);
        check_val("rst_wr", 32'(mem_write), 32'd0);
        check_val("rst_wdata", 32'(mem_writedata), 32'd0);
        check_val("rst_clken", 32'(mem_clken), 32'd1);
        run_chk = 1;
        reset   = 1'b0;
        tick();

        // Single read of a preloaded cell
        do_req(0, 1'b0, 10'd5, 8'h00);
        repeat (3) tick();

        // Contention: both hold reads for four cycles
        req_i = 2'b11; we_i = 2'b00;
        for (int k = 0; k < 4; k++) begin
            addr_i = {10'(20 + k), 10'(10 + k)};
            tick();
        end
        req_i = 2'b00;
        repeat (3) tick();

        // Write then read the last cell
        do_req(0, 1'b1, 10'd759, 8'hA5);
        do_req(0, 1'b0, 10'd759, 8'h00);
        // Out-of-range read from the LCD side
        do_req(1, 1'b0, 10'd800, 8'h00);
        repeat (3) tick();
        check_val("aerr_sticky", 32'(addr_err), 32'd1);

        // Full clear with a pending LCD request, right after a granted read
        do_req(0, 1'b0, 10'd7, 8'h00);
        fork
            begin
                clear_start = 1'b1; clear_value = 8'h07;
                tick();
                clear_start = 1'b0;
            end
            do_req(1, 1'b0, 10'd3, 8'h00);
        join
        repeat (3) tick();
        check_val("done_once", 32'(n_done), 32'd1);
        do_req(1, 1'b0, 10'd0, 8'h00);
        do_req(0, 1'b0, 10'd380, 8'h00);
        do_req(1, 1'b0, 10'd759, 8'h00);

        // Reset in the middle of a second clear
        do_req(0, 1'b1, 10'd299, 8'hEE);
        do_req(0, 1'b1, 10'd301, 8'h99);
        clear_start = 1'b1; clear_value = 8'h07;
        tick();
        clear_start = 1'b0;
        repeat (300) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("midrst_busy", 32'(clear_busy), 32'd0);
        tick();
        do_req(0, 1'b0, 10'd299, 8'h00);
        do_req(0, 1'b0, 10'd301, 8'h00);
        check_val("midrst_aerr", 32'(addr_err), 32'd0);
        repeat (4) tick();

        check_val("done_total", 32'(n_done), 32'd1);
        check_val("sb_drained", 32'(sb.size()), 32'd0);
        run_chk = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_snake_mem_arbiter
`default_nettype wire
